// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: shared types, digit indices and segment patterns for the display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 7;

  typedef logic [2:0] idx_t;
  typedef logic [3:0] digit_t;
  typedef digit_t [NUM_DIGITS-1:0] snap_t;

  localparam idx_t IDX_TENTHS     = 3'd0;
  localparam idx_t IDX_SEC_UNITS  = 3'd1;
  localparam idx_t IDX_SEC_TENS   = 3'd2;
  localparam idx_t IDX_MIN_UNITS  = 3'd3;
  localparam idx_t IDX_MIN_TENS   = 3'd4;
  localparam idx_t IDX_HOUR_UNITS = 3'd5;
  localparam idx_t IDX_HOUR_TENS  = 3'd6;

  // Logical segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Decimal point after tenths-separator digits: s.t, m.s, h.m
  localparam logic [6:0] DP_MASK = 7'b0101010;

  function automatic logic [6:0] digit_onehot(input idx_t i);
    return 7'b0000001 << i;
  endfunction

endpackage

// File: rtl/clock_display_scan_bcd.sv
// bcd_to_seg7: combinational BCD digit to logical 7-segment pattern, dash for codes above 9.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 renders as a dash.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: 7-digit multiplexed time display with blank interval and per-frame digit snapshot.
// Latency: an/seg/dp/frame_done registered; inputs appear from the next frame (snapshot at frame start).
// Backpressure: none, free-running scan. Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] point1,
  input  logic [3:0] sec1,
  input  logic [2:0] sec2,
  input  logic [3:0] min1,
  input  logic [2:0] min2,
  input  logic [3:0] hour1,
  input  logic [1:0] hour2,
  output logic [6:0] seg,
  output logic       dp,
  output logic [6:0] an,
  output logic       frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [6:0] AN_OFF_PHYS  = AN_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_OFF_PHYS = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  idx_t             idx, idx_nxt;
  snap_t            snap, snap_nxt;
  logic             take_snap;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic [6:0]       an_log, seg_log;
  logic             dp_log, frame_log;

  // Phase sequencing: each digit gets BLANK then DRIVE; idx advances as DRIVE ends.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_HOUR_TENS) ? IDX_TENTHS : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
        idx_nxt   = IDX_TENTHS;
      end
    endcase
  end

  assign take_snap = (state == BLANK) && (idx == IDX_TENTHS) && (cnt == '0);

  // Latch all digits together at frame start so a frame never mixes old and new time.
  always_comb begin
    snap_nxt = snap;
    if (take_snap) begin
      snap_nxt[IDX_TENTHS]     = point1;
      snap_nxt[IDX_SEC_UNITS]  = sec1;
      snap_nxt[IDX_SEC_TENS]   = {1'b0, sec2};
      snap_nxt[IDX_MIN_UNITS]  = min1;
      snap_nxt[IDX_MIN_TENS]   = {1'b0, min2};
      snap_nxt[IDX_HOUR_UNITS] = hour1;
      snap_nxt[IDX_HOUR_TENS]  = {2'b00, hour2};
    end
  end

  // Outputs are computed for the upcoming cycle so the registers line up with state.
  assign cur_digit = snap_nxt[idx_nxt];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Logical (active-high) display values; BLANK keeps everything dark.
  always_comb begin
    an_log    = '0;
    seg_log   = SEG_OFF;
    dp_log    = 1'b0;
    frame_log = 1'b0;
    if (state_nxt == DRIVE) begin
      an_log    = digit_onehot(idx_nxt);
      seg_log   = dec_seg;
      dp_log    = DP_MASK[idx_nxt];
      frame_log = (idx_nxt == IDX_HOUR_TENS) && (cnt_nxt == DRIVE_LAST);
`ifdef LEADING_ZERO_BLANK_EN
      // Dark digit but anode still selected, so scan timing is identical.
      if ((idx_nxt == IDX_HOUR_TENS) && (snap_nxt[IDX_HOUR_TENS] == 4'd0)) begin
        seg_log = SEG_OFF;
        dp_log  = 1'b0;
      end
`endif
    end
  end

  // Scan state and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= IDX_TENTHS;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
    end
  end

  // Output register; pin polarity applied here and nowhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF_PHYS;
      seg        <= SEG_OFF_PHYS;
      dp         <= SEG_ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      an         <= AN_ACTIVE_LOW ? ~an_log : an_log;
      seg        <= SEG_ACTIVE_LOW ? ~seg_log : seg_log;
      dp         <= SEG_ACTIVE_LOW ? ~dp_log : dp_log;
      frame_done <= frame_log;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: table vectors scored per digit through a queue, plus reset/coherency sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_display_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
  localparam bit SEG_AL    = 1'b1;
  localparam bit AN_AL     = 1'b1;
  localparam int FRAME     = 7 * (SCAN_DIV + BLANK_CYC);
  localparam logic [6:0] AN_OFF = AN_AL ? 7'h7F : 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] point1 = '0, sec1 = '0, min1 = '0, hour1 = '0;
  logic [2:0] sec2 = '0, min2 = '0;
  logic [1:0] hour2 = '0;
  logic [6:0] seg, an;
  logic       dp, frame_done;

  always #5 clk = ~clk;

  clock_display_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .SEG_ACTIVE_LOW (SEG_AL),
    .AN_ACTIVE_LOW  (AN_AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .point1     (point1),
    .sec1       (sec1),
    .sec2       (sec2),
    .min1       (min1),
    .min2       (min2),
    .hour1      (hour1),
    .hour2      (hour2),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [1:0]      h2;
    logic [3:0]      h1;
    logic [2:0]      m2;
    logic [3:0]      m1;
    logic [2:0]      s2;
    logic [3:0]      s1;
    logic [3:0]      p1;
    logic [6:0][6:0] segs;  // expected logical pattern per digit index
  } vec_t;

  typedef struct {
    int         idx;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];
  vec_t v_old, v_new;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic vec_t mk(input logic [1:0] h2, input logic [3:0] h1, input logic [2:0] m2,
                              input logic [3:0] m1, input logic [2:0] s2, input logic [3:0] s1,
                              input logic [3:0] p1, input logic [6:0][6:0] segs);
    vec_t v;
    v.h2 = h2; v.h1 = h1; v.m2 = m2; v.m1 = m1; v.s2 = s2; v.s1 = s1; v.p1 = p1;
    v.segs = segs;
    return v;
  endfunction

  function automatic logic [6:0] an_pol(input int i);
    logic [6:0] a;
    a = 7'b0000001 << i;
    return AN_AL ? ~a : a;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_AL ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return SEG_AL ? ~d : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    hour2 = v.h2; hour1 = v.h1; min2 = v.m2; min1 = v.m1;
    sec2 = v.s2; sec1 = v.s1; point1 = v.p1;
  endtask

  task automatic push_frame(input vec_t v);
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e.idx = i;
      e.seg = v.segs[i];
      e.dp  = (i == 1 || i == 3 || i == 5);
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 6 && v.h2 == 2'd0) e.seg = 7'h00;
`endif
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2 * FRAME + 10);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_digit(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an != an_pol(i) && n < 2 * FRAME + 10);
    check("reach_digit", an, an_pol(i));
  endtask

  // Right after rst release: 2 blank cycles, digit 0 for 4 cycles, 2 blank, then digit 1.
  task automatic check_restart(input logic [6:0] s0, input logic [6:0] s1);
    check("rel_c0_an", an, AN_OFF);
    @(negedge clk);
    check("rel_c1_an", an, AN_OFF);
    check("rel_c1_seg", seg, seg_pol(7'h00));
    for (int k = 0; k < SCAN_DIV; k++) begin
      @(negedge clk);
      check("rel_d0_an", an, an_pol(0));
      check("rel_d0_seg", seg, seg_pol(s0));
      check("rel_d0_dp", dp, dp_pol(1'b0));
    end
    for (int k = 0; k < BLANK_CYC; k++) begin
      @(negedge clk);
      check("rel_blank_an", an, AN_OFF);
      check("rel_blank_seg", seg, seg_pol(7'h00));
      check("rel_blank_dp", dp, dp_pol(1'b0));
    end
    @(negedge clk);
    check("rel_d1_an", an, an_pol(1));
    check("rel_d1_seg", seg, seg_pol(s1));
    check("rel_d1_dp", dp, dp_pol(1'b1));
  endtask

  // Scoreboard consumer: compare first cycle of each driven digit; track frame_done spacing.
  task automatic monitor();
    logic [6:0] prev_an;
    int         last_fd;
    bit         have_prev;
    exp_t       e;
    prev_an   = AN_OFF;
    last_fd   = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_prev = 1'b0;
        prev_an   = AN_OFF;
      end else begin
        if (frame_done) begin
          check("fd_on_digit6", an, an_pol(6));
          if (have_prev) check("frame_period", cyc - last_fd, FRAME);
          have_prev = 1'b1;
          last_fd   = cyc;
        end
        if (an != prev_an && an != AN_OFF && sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_an", an, an_pol(e.idx));
          check("sb_seg", seg, seg_pol(e.seg));
          check("sb_dp", dp, dp_pol(e.dp));
        end
        prev_an = an;
      end
    end
  endtask

  initial begin
    vecs[0] = mk(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 4'd7,
                 {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07});
    vecs[1] = mk(2'd0, 4'd5, 3'd0, 4'd8, 3'd0, 4'd9, 4'd0,
                 {7'h3F, 7'h6D, 7'h3F, 7'h7F, 7'h3F, 7'h6F, 7'h3F});
    vecs[2] = mk(2'd2, 4'd3, 3'd1, 4'hB, 3'd4, 4'd7, 4'd8,
                 {7'h5B, 7'h4F, 7'h06, 7'h40, 7'h66, 7'h07, 7'h7F});
    vecs[3] = mk(2'd3, 4'hF, 3'd7, 4'd9, 3'd6, 4'hE, 4'hD,
                 {7'h4F, 7'h40, 7'h07, 7'h6F, 7'h7D, 7'h40, 7'h40});
    v_old   = mk(2'd0, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9, 4'd9,
                 {7'h3F, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h6F});
    v_new   = mk(2'd1, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 4'd0,
                 {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});

    fork
      monitor();
    join_none

    // Reset state
    apply(vecs[0]);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", an, AN_OFF);
    check("rst_seg", seg, seg_pol(7'h00));
    check("rst_dp", dp, dp_pol(1'b0));
    check("rst_frame_done", frame_done, 0);

    // Release and first-digit timing
    rst = 1'b0;
    check_restart(7'h07, 7'h7D);

    // Table vectors, each displayed for one full frame
    for (int i = 0; i < 4; i++) begin
      wait_frame_done();
      if (i > 0) check("sb_drained", sb.size(), 0);
      apply(vecs[i]);
      push_frame(vecs[i]);
    end
    wait_frame_done();
    check("sb_drained", sb.size(), 0);

    // Coherency: inputs roll over while digit 3 of the old frame is shown
    apply(v_old);
    push_frame(v_old);
    wait_digit(3);
    apply(v_new);
    wait_frame_done();
    check("coh_old_drained", sb.size(), 0);
    push_frame(v_new);
    wait_frame_done();
    check("coh_new_drained", sb.size(), 0);

    // Async reset mid-DRIVE of digit 4
    wait_digit(4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_an", an, AN_OFF);
    check("arst_seg", seg, seg_pol(7'h00));
    check("arst_dp", dp, dp_pol(1'b0));
    check("arst_frame_done", frame_done, 0);
    sb.delete();
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_restart(7'h07, 7'h7D);
    wait_frame_done();
    push_frame(vecs[0]);
    wait_frame_done();
    check("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
